strt_chk_vote: RTL and testbench

- Parametrised start-bit validator for the UART RX path. Successor to the single-sample start check.
- Owns its own input synchroniser, falling-edge detector, oversampling edge counter and N-sample majority vote.
- Reports a valid start or a glitch once per candidate start bit, and keeps a saturating glitch count.
- Sits between the RX pin and the RX FSM. A strt_valid pulse hands the frame to the data-sampling stage.

---
 rtl/strt_chk_vote.sv | 168 ++++++++++++++++
 tb/tb_strt_chk_vote.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/strt_chk_vote.sv
// strt_chk_vote: start-bit validator for the UART RX path.
// Synchronises RX_IN, detects a falling edge, counts one oversampled bit
// period and takes a VOTE_N-sample majority around the bit centre.
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   RX_IN          raw serial line (idle 1)
//   Prescale       oversampling ratio, captured on the falling-edge cycle
//   strt_chk_en    arms the checker
//   glitch_clr     synchronous clear of glitch_cnt
//   busy           high while counting or deciding
//   sampled_bit    last majority result, held between decisions
//   strt_valid     one-cycle pulse: start bit confirmed
//   strt_glitch    one-cycle pulse: start bit rejected
//   glitch_cnt     saturating count of rejected starts
module strt_chk_vote #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned VOTE_N     = 3,
  parameter int unsigned GCNT_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_chk_en,
  input  logic                  glitch_clr,
  output logic                  busy,
  output logic                  sampled_bit,
  output logic                  strt_valid,
  output logic                  strt_glitch,
  output logic [GCNT_W-1:0]     glitch_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DECIDE} state_t;

  localparam int unsigned           HALF  = (VOTE_N - 1) / 2;
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

  state_t                  state_q, state_d;
  logic                    rx_m_q, rx_m_d;
  logic                    rx_s_q, rx_s_d;
  logic                    rx_prev_q, rx_prev_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0]   p_lat_q, p_lat_d;
  logic [VOTE_N-1:0]       samp_q, samp_d;
  logic                    busy_q, busy_d;
  logic                    sampled_bit_q, sampled_bit_d;
  logic                    strt_valid_q, strt_valid_d;
  logic                    strt_glitch_q, strt_glitch_d;
  logic [GCNT_W-1:0]       glitch_cnt_q, glitch_cnt_d;

  logic                    fe;
  logic [PRESCALE_W-1:0]   p_even;
  logic [PRESCALE_W-1:0]   p_cap;
  logic [PRESCALE_W-1:0]   lo_idx;
  logic [3:0]              ones;
  logic                    maj;
  logic                    last_cnt;

  always_comb begin
    fe       = rx_prev_q & ~rx_s_q;
    p_even   = {Prescale[PRESCALE_W-1:1], 1'b0};
    p_cap    = (p_even < P_MIN) ? P_MIN : p_even;
    lo_idx   = (p_lat_q >> 1) - PRESCALE_W'(HALF);
    last_cnt = (edge_cnt_q == (p_lat_q - PRESCALE_W'(1)));
    ones     = '0;
    for (int unsigned i = 0; i < VOTE_N; i++) begin
      ones = ones + 4'(samp_q[i]);
    end
    maj = (ones > 4'(VOTE_N / 2));
  end

  always_comb begin
    rx_m_d        = RX_IN;
    rx_s_d        = rx_m_q;
    rx_prev_d     = rx_s_q;
    state_d       = state_q;
    edge_cnt_d    = edge_cnt_q;
    p_lat_d       = p_lat_q;
    samp_d        = samp_q;
    sampled_bit_d = sampled_bit_q;
    strt_valid_d  = 1'b0;
    strt_glitch_d = 1'b0;
    glitch_cnt_d  = glitch_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (strt_chk_en && rx_s_q) state_d = ARMED;
      end
      ARMED: begin
        if (!strt_chk_en) begin
          state_d = IDLE;
        end else if (fe) begin
          state_d    = COUNT;
          edge_cnt_d = '0;
          p_lat_d    = p_cap;
        end
      end
      COUNT: begin
        if (!strt_chk_en) begin
          state_d = IDLE;
        end else begin
          edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
          for (int unsigned i = 0; i < VOTE_N; i++) begin
            if (edge_cnt_q == lo_idx + PRESCALE_W'(i)) samp_d[i] = rx_s_q;
          end
          // All samples lie strictly before the last count cycle, so the
          // vote is settled here and the pulse can be registered to land
          // exactly on the DECIDE cycle.
          if (last_cnt) begin
            state_d       = DECIDE;
            strt_valid_d  = ~maj;
            strt_glitch_d = maj;
          end
        end
      end
      DECIDE: begin
        sampled_bit_d = strt_glitch_q;
        if (strt_glitch_q) begin
          if (glitch_cnt_q != '1) glitch_cnt_d = glitch_cnt_q + GCNT_W'(1);
          state_d = strt_chk_en ? ARMED : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (glitch_clr) glitch_cnt_d = '0;
    busy_d = (state_d == COUNT) || (state_d == DECIDE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m_q        <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= IDLE;
      edge_cnt_q    <= '0;
      p_lat_q       <= P_MIN;
      samp_q        <= '1;
      busy_q        <= 1'b0;
      sampled_bit_q <= 1'b1;
      strt_valid_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      glitch_cnt_q  <= '0;
    end else begin
      rx_m_q        <= rx_m_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      p_lat_q       <= p_lat_d;
      samp_q        <= samp_d;
      busy_q        <= busy_d;
      sampled_bit_q <= sampled_bit_d;
      strt_valid_q  <= strt_valid_d;
      strt_glitch_q <= strt_glitch_d;
      glitch_cnt_q  <= glitch_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign sampled_bit = sampled_bit_q;
  assign strt_valid  = strt_valid_q;
  assign strt_glitch = strt_glitch_q;
  assign glitch_cnt  = glitch_cnt_q;

endmodule

// File: tb/tb_strt_chk_vote.sv
// tb_strt_chk_vote: self-checking bench for strt_chk_vote.
// Each start candidate is a per-cycle line waveform; the expected pulse,
// busy window, vote result and glitch count are derived from the waveform
// and the effective prescale with plain arithmetic.
module tb_strt_chk_vote;

  localparam int PW  = 6;
  localparam int VN  = 3;
  localparam int GW  = 2;
  localparam int LEN = 72;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          strt_chk_en;
  logic          glitch_clr;
  logic          busy;
  logic          sampled_bit;
  logic          strt_valid;
  logic          strt_glitch;
  logic [GW-1:0] glitch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit wave [LEN];
  int model_cnt = 0;
  bit model_sb  = 1'b1;

  strt_chk_vote #(
    .PRESCALE_W(PW),
    .VOTE_N    (VN),
    .GCNT_W    (GW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .strt_chk_en(strt_chk_en),
    .glitch_clr (glitch_clr),
    .busy       (busy),
    .sampled_bit(sampled_bit),
    .strt_valid (strt_valid),
    .strt_glitch(strt_glitch),
    .glitch_cnt (glitch_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff_p(input int pres);
    int e;
    e = pres & ~1;
    return (e < 8) ? 8 : e;
  endfunction

  function automatic void fill_low(input int n_low);
    for (int j = 0; j < LEN; j++) wave[j] = (j >= n_low);
  endfunction

  // Line low for one cycle, random over the bit period, high afterwards.
  function automatic void fill_random(input int p);
    bit mostly_low;
    mostly_low = ($urandom_range(0, 1) == 1);
    for (int j = 0; j < LEN; j++) begin
      if (j == 0)     wave[j] = 1'b0;
      else if (j > p) wave[j] = 1'b1;
      else if (mostly_low) wave[j] = ($urandom_range(0, 3) == 0);
      else                 wave[j] = ($urandom_range(0, 3) != 0);
    end
  endfunction

  // Line level driven in cycle k+1 of the waveform is seen by the checker
  // at edge_cnt == k, and the decision lands in cycle p+3.
  task automatic run_start(input string tag, input int pres, input bit clr_pulse,
                           input int drop_at, input int rst_at);
    int p, lo, ones;
    bit maj, aborted, exp_busy, exp_v, exp_g;
    p  = eff_p(pres);
    lo = p / 2 - (VN - 1) / 2;
    ones = 0;
    for (int i = 0; i < VN; i++) ones += int'(wave[lo + 1 + i]);
    maj     = (2 * ones > VN);
    aborted = (drop_at >= 0) || (rst_at >= 0);
    for (int n = 0; n < LEN; n++) begin
      RX_IN      = wave[n];
      Prescale   = (n < 3) ? PW'(pres) : PW'($urandom_range(0, 63));
      glitch_clr = clr_pulse && (n == p + 3);
      if (n == drop_at) strt_chk_en = 1'b0;
      if (rst_at >= 0) begin
        if (n == rst_at) begin
          RST = 1'b1;
          strt_chk_en = 1'b0;
          model_cnt = 0;
          model_sb  = 1'b1;
        end
        if (n == rst_at + 2) RST = 1'b0;
        if (n == rst_at + 6) strt_chk_en = 1'b1;
      end
      #1;
      exp_busy = (n >= 3) && (n <= p + 3) && (drop_at < 0 || n <= drop_at) &&
                 (rst_at < 0 || n < rst_at);
      exp_v = !aborted && (n == p + 3) && !maj;
      exp_g = !aborted && (n == p + 3) && maj;
      check($sformatf("%s.busy@%0d", tag, n), busy, exp_busy);
      check($sformatf("%s.valid@%0d", tag, n), strt_valid, exp_v);
      check($sformatf("%s.glitch@%0d", tag, n), strt_glitch, exp_g);
      if (n == p + 4 || n == LEN - 1 || n == rst_at) begin
        check($sformatf("%s.sampled_bit@%0d", tag, n), sampled_bit, model_sb);
        check($sformatf("%s.glitch_cnt@%0d", tag, n), glitch_cnt, model_cnt);
      end
      if (!aborted && n == p + 3) begin
        model_sb = maj;
        if (clr_pulse) model_cnt = 0;
        else if (maj && model_cnt < (1 << GW) - 1) model_cnt++;
      end
      @(posedge CLK);
      #1;
    end
    RX_IN       = 1'b1;
    RST         = 1'b0;
    strt_chk_en = 1'b1;
    glitch_clr  = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin
    int pres;
    RST         = 1'b1;
    RX_IN       = 1'b1;
    strt_chk_en = 1'b1;
    glitch_clr  = 1'b0;
    Prescale    = PW'(16);
    repeat (3) @(posedge CLK);
    #1;
    check("rst.busy", busy, 0);
    check("rst.valid", strt_valid, 0);
    check("rst.glitch", strt_glitch, 0);
    check("rst.sampled_bit", sampled_bit, 1);
    check("rst.glitch_cnt", glitch_cnt, 0);
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;

    fill_low(32);           run_start("t1_valid", 16, 1'b0, -1, -1);
    fill_low(4);            run_start("t2_glitch", 16, 1'b0, -1, -1);
    fill_low(32);           run_start("t2_revalid", 16, 1'b0, -1, -1);
    fill_low(32); wave[9] = 1'b1;
                            run_start("t3_one_high", 16, 1'b0, -1, -1);
    fill_low(32);           run_start("t4_clamp", 5, 1'b0, -1, -1);
    fill_low(32);           run_start("t4_odd", 17, 1'b0, -1, -1);
    fill_low(32);           run_start("t5_drop", 16, 1'b0, 8, -1);
    fill_low(LEN);          run_start("t5_rst", 16, 1'b0, -1, 13);
    for (int k = 0; k < 5; k++) begin
      fill_low(4);          run_start($sformatf("t6_sat%0d", k), 16, 1'b0, -1, -1);
    end
    fill_low(4);            run_start("t6_clr", 16, 1'b1, -1, -1);

    for (int k = 0; k < 40; k++) begin
      pres = $urandom_range(0, 63);
      fill_random(eff_p(pres));
      run_start($sformatf("rnd%0d", k), pres, ($urandom_range(0, 7) == 0), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
